// File: rtl/brlite_out_arbiter_pkg.sv
// brlite_out_arbiter_pkg: shared types for the BrLite output arbiter
package brlite_out_arbiter_pkg;
    localparam int BRLITE_ARB_NREQ = 3;
    typedef struct packed {
        logic [7:0]  src;
        logic [7:0]  tgt;
        logic [7:0]  service;
        logic [31:0] payload;
    } brlite_out_t;
    typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} brlite_arb_state_t;
endpackage

// File: rtl/brlite_out_arbiter_rr_pick.sv
// brlite_out_arbiter_rr_pick: first set request at or after ptr, modulo N
module brlite_out_arbiter_rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] sel,
    output logic          any
);
    int idx;
    assign any = |req;
    // scan from the farthest offset down so the nearest set bit wins
    always_comb begin
        sel = '0;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) sel = IW'(idx);
        end
    end
endmodule

// File: rtl/brlite_out_arbiter.sv
// brlite_out_arbiter: round-robin sharing of the BrLite output port among N_REQ requesters
import brlite_out_arbiter_pkg::*;
module brlite_out_arbiter #(
    parameter int N_REQ       = BRLITE_ARB_NREQ,
    parameter int STALL_CNT_W = 32,
    localparam int IW         = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    output logic [N_REQ-1:0]       ack_o,
    input  brlite_out_t            data_i [N_REQ],
    input  logic                   br_local_busy_i,
    output logic                   br_req_o,
    input  logic                   br_ack_i,
    output brlite_out_t            br_data_o,
    output logic                   grant_valid_o,
    output logic [IW-1:0]          grant_idx_o,
    input  logic                   stall_clr_i,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);
    brlite_arb_state_t state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d, sel, idx_d;
    logic             any, req_d, gv_d;
    logic [N_REQ-1:0] ack_d;
    brlite_out_t      data_d;

    brlite_out_arbiter_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req(req_i),
        .ptr(rr_ptr_q),
        .sel(sel),
        .any(any)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        req_d    = br_req_o;
        data_d   = br_data_o;
        idx_d    = grant_idx_o;
        gv_d     = grant_valid_o;
        ack_d    = '0;
        case (state_q)
            IDLE: if (any && !br_local_busy_i) begin
                state_d = WAIT_ACK;
                req_d   = 1'b1;
                data_d  = data_i[sel];
                idx_d   = sel;
                gv_d    = 1'b1;
            end
            WAIT_ACK: if (br_ack_i) begin
                state_d            = RELEASE;
                req_d              = 1'b0;
                ack_d[grant_idx_o] = 1'b1;
                rr_ptr_d           = (grant_idx_o == IW'(N_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
            end
            RELEASE: begin
                state_d = IDLE;
                gv_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            br_req_o      <= 1'b0;
            br_data_o     <= '0;
            grant_idx_o   <= '0;
            grant_valid_o <= 1'b0;
            ack_o         <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            br_req_o      <= req_d;
            br_data_o     <= data_d;
            grant_idx_o   <= idx_d;
            grant_valid_o <= gv_d;
            ack_o         <= ack_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            stall_cnt_o <= '0;
        else if (stall_clr_i)
            stall_cnt_o <= '0;
        else if (state_q == WAIT_ACK && !br_ack_i && !(&stall_cnt_o))
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_brlite_out_arbiter.sv
// tb_brlite_out_arbiter: directed self-checking bench for brlite_out_arbiter
import brlite_out_arbiter_pkg::*;
module tb_brlite_out_arbiter;
    localparam int N = 3;
    localparam int W = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] ack_o;
    brlite_out_t data_i [N];
    logic        br_local_busy_i = 1'b0;
    logic        br_req_o;
    logic        br_ack_i = 1'b0;
    brlite_out_t br_data_o;
    logic        grant_valid_o;
    logic [1:0]  grant_idx_o;
    logic        stall_clr_i = 1'b0;
    logic [W-1:0] stall_cnt_o;
    int total = 0;
    int bad = 0;

    brlite_out_arbiter #(.N_REQ(N), .STALL_CNT_W(W)) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_i(req_i),
        .ack_o(ack_o),
        .data_i(data_i),
        .br_local_busy_i(br_local_busy_i),
        .br_req_o(br_req_o),
        .br_ack_i(br_ack_i),
        .br_data_o(br_data_o),
        .grant_valid_o(grant_valid_o),
        .grant_idx_o(grant_idx_o),
        .stall_clr_i(stall_clr_i),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = '0;
        br_ack_i = 1'b0;
        br_local_busy_i = 1'b0;
        stall_clr_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (br_req_o !== 1'b0) begin bad++; $display("FAIL rst_br_req got=%b exp=0", br_req_o); end
        total++; if (ack_o !== 3'b000) begin bad++; $display("FAIL rst_ack got=%b exp=000", ack_o); end
        total++; if (br_data_o !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", br_data_o); end
        total++; if (grant_valid_o !== 1'b0) begin bad++; $display("FAIL rst_gv got=%b exp=0", grant_valid_o); end
        total++; if (grant_idx_o !== 2'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", grant_idx_o); end
        total++; if (stall_cnt_o !== 4'd0) begin bad++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt_o); end
    endtask

    task automatic test_single();
        req_i = 3'b001;
        tick();
        total++; if (br_req_o !== 1'b1) begin bad++; $display("FAIL single_req got=%b exp=1", br_req_o); end
        total++; if (br_data_o.payload !== 32'hCAFE0001) begin bad++; $display("FAIL single_payload got=%h exp=cafe0001", br_data_o.payload); end
        total++; if (grant_idx_o !== 2'd0 || grant_valid_o !== 1'b1) begin bad++; $display("FAIL single_grant idx=%0d gv=%b exp idx=0 gv=1", grant_idx_o, grant_valid_o); end
        tick();
        tick();
        br_ack_i = 1'b1;
        total++; if (stall_cnt_o !== 4'd2) begin bad++; $display("FAIL single_stall got=%0d exp=2", stall_cnt_o); end
        tick();
        total++; if (ack_o !== 3'b001 || br_req_o !== 1'b0) begin bad++; $display("FAIL single_ack ack=%b req=%b exp ack=001 req=0", ack_o, br_req_o); end
        br_ack_i = 1'b0;
        req_i = '0;
        tick();
        total++; if (ack_o !== 3'b000 || grant_valid_o !== 1'b0) begin bad++; $display("FAIL single_release ack=%b gv=%b exp ack=000 gv=0", ack_o, grant_valid_o); end
        total++; if (br_data_o.payload !== 32'hCAFE0001 || stall_cnt_o !== 4'd2) begin bad++; $display("FAIL single_hold payload=%h stall=%0d exp cafe0001/2", br_data_o.payload, stall_cnt_o); end
    endtask

    task automatic test_rotation();
        do_reset();
        req_i = 3'b111;
        br_ack_i = 1'b1;
        for (int g = 0; g < 6; g++) begin
            tick();
            total++; if (br_req_o !== 1'b1 || grant_idx_o !== 2'(g % 3)) begin bad++; $display("FAIL rot_grant%0d req=%b idx=%0d exp req=1 idx=%0d", g, br_req_o, grant_idx_o, g % 3); end
            tick();
            total++; if (ack_o !== 3'(1 << (g % 3))) begin bad++; $display("FAIL rot_ack%0d got=%b exp=%b", g, ack_o, 3'(1 << (g % 3))); end
            tick();
            total++; if (br_req_o !== 1'b0 || ack_o !== 3'b000) begin bad++; $display("FAIL rot_release%0d req=%b ack=%b exp 0/000", g, br_req_o, ack_o); end
        end
        req_i = '0;
        br_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_busy();
        br_local_busy_i = 1'b1;
        req_i = 3'b010;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if (br_req_o !== 1'b0) begin bad++; $display("FAIL busy_hold%0d got=%b exp=0", c, br_req_o); end
        end
        br_local_busy_i = 1'b0;
        tick();
        total++; if (br_req_o !== 1'b1 || grant_idx_o !== 2'd1) begin bad++; $display("FAIL busy_grant req=%b idx=%0d exp 1/1", br_req_o, grant_idx_o); end
        br_local_busy_i = 1'b1;
        br_ack_i = 1'b1;
        tick();
        total++; if (ack_o !== 3'b010) begin bad++; $display("FAIL busy_ack got=%b exp=010", ack_o); end
        br_local_busy_i = 1'b0;
        br_ack_i = 1'b0;
        req_i = '0;
        tick();
    endtask

    task automatic test_wrap();
        req_i = 3'b011;
        tick();
        total++; if (grant_idx_o !== 2'd0 || br_data_o.payload !== 32'hCAFE0001) begin bad++; $display("FAIL wrap_first idx=%0d payload=%h exp 0/cafe0001", grant_idx_o, br_data_o.payload); end
        br_ack_i = 1'b1;
        tick();
        total++; if (ack_o !== 3'b001) begin bad++; $display("FAIL wrap_ack0 got=%b exp=001", ack_o); end
        br_ack_i = 1'b0;
        req_i = 3'b010;
        tick();
        tick();
        total++; if (grant_idx_o !== 2'd1 || br_data_o.payload !== 32'hBEEF0002) begin bad++; $display("FAIL wrap_second idx=%0d payload=%h exp 1/beef0002", grant_idx_o, br_data_o.payload); end
        br_ack_i = 1'b1;
        tick();
        total++; if (ack_o !== 3'b010) begin bad++; $display("FAIL wrap_ack1 got=%b exp=010", ack_o); end
        br_ack_i = 1'b0;
        req_i = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        req_i = 3'b100;
        tick();
        total++; if (grant_idx_o !== 2'd2 || br_req_o !== 1'b1) begin bad++; $display("FAIL mid_grant idx=%0d req=%b exp 2/1", grant_idx_o, br_req_o); end
        tick();
        #2 rst_ni = 1'b0;
        #1;
        total++; if (br_req_o !== 1'b0 || grant_valid_o !== 1'b0 || grant_idx_o !== 2'd0) begin bad++; $display("FAIL mid_async req=%b gv=%b idx=%0d exp 0/0/0", br_req_o, grant_valid_o, grant_idx_o); end
        total++; if (br_data_o !== '0 || stall_cnt_o !== 4'd0) begin bad++; $display("FAIL mid_async_data data=%h stall=%0d exp 0/0", br_data_o, stall_cnt_o); end
        br_ack_i = 1'b1;
        tick();
        total++; if (ack_o !== 3'b000) begin bad++; $display("FAIL mid_noack got=%b exp=000", ack_o); end
        br_ack_i = 1'b0;
        rst_ni = 1'b1;
        req_i = 3'b111;
        tick();
        total++; if (grant_idx_o !== 2'd0 || br_req_o !== 1'b1) begin bad++; $display("FAIL mid_regrant idx=%0d req=%b exp 0/1", grant_idx_o, br_req_o); end
        br_ack_i = 1'b1;
        tick();
        br_ack_i = 1'b0;
        req_i = '0;
        tick();
    endtask

    task automatic test_idle_ack_and_saturate();
        br_ack_i = 1'b1;
        tick();
        tick();
        total++; if (ack_o !== 3'b000 || br_req_o !== 1'b0 || grant_valid_o !== 1'b0) begin bad++; $display("FAIL idle_ack ack=%b req=%b gv=%b exp 000/0/0", ack_o, br_req_o, grant_valid_o); end
        br_ack_i = 1'b0;
        req_i = 3'b001;
        tick();
        total++; if (br_req_o !== 1'b1 || grant_idx_o !== 2'd0) begin bad++; $display("FAIL sat_grant req=%b idx=%0d exp 1/0", br_req_o, grant_idx_o); end
        req_i = 3'b000;
        for (int c = 0; c < 20; c++) tick();
        total++; if (stall_cnt_o !== 4'hF) begin bad++; $display("FAIL sat_full got=%h exp=f", stall_cnt_o); end
        tick();
        total++; if (stall_cnt_o !== 4'hF || br_req_o !== 1'b1) begin bad++; $display("FAIL sat_hold cnt=%h req=%b exp f/1", stall_cnt_o, br_req_o); end
        stall_clr_i = 1'b1;
        tick();
        total++; if (stall_cnt_o !== 4'h0) begin bad++; $display("FAIL sat_clr got=%h exp=0", stall_cnt_o); end
        stall_clr_i = 1'b0;
        br_ack_i = 1'b1;
        tick();
        total++; if (ack_o !== 3'b001) begin bad++; $display("FAIL drop_ack got=%b exp=001", ack_o); end
        br_ack_i = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) data_i[i] = '0;
        data_i[0].payload = 32'hCAFE0001;
        data_i[1].payload = 32'hBEEF0002;
        data_i[2].payload = 32'hF00D0003;
        data_i[1].service = 8'h5A;
        test_reset();
        test_single();
        test_rotation();
        test_busy();
        test_wrap();
        test_reset_mid();
        test_idle_ack_and_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/brlite_out_arbiter.md
Name: brlite_out_arbiter

Overview:
Shares the single BrLite output port (req/ack/data) among N local requesters, e.g. the NI software send path, the monitor publish path and the kernel service path. It applies round-robin arbitration and gates new grants on the local-busy indication. The granted packet is latched and held stable on the BrLite output until the router acknowledges it. It sits between the NI-class producers and the BrLite router local input.

Parameters:
N_REQ, 3, number of requesters (2..8)
STALL_CNT_W, 32, width of saturating stall counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  N_REQ  per-requester request level; sticky until its ack_o pulse
ack_o  out  N_REQ  per-requester one-cycle acknowledge pulse
data_i  in  N_REQ x brlite_out_t  per-requester packet; stable while req_i high
br_local_busy_i  in  1  router local port busy; blocks new grants
br_req_o  out  1  request to router
br_ack_i  in  1  router acknowledge, one-cycle pulse
br_data_o  out  brlite_out_t  granted packet
grant_valid_o  out  1  a grant is in progress
grant_idx_o  out  $clog2(N_REQ)  index of the current or last grantee
stall_clr_i  in  1  synchronous clear of the stall counter
stall_cnt_o  out  STALL_CNT_W  cycles with br_req_o=1 and br_ack_i=0, saturating

Behaviour:
- Reset values: br_req_o=0, ack_o=0, br_data_o='0, grant_valid_o=0, grant_idx_o=0, stall_cnt_o=0, rr_ptr=0, state=IDLE. Reset mid-transfer aborts silently and no ack_o is issued.
- FSM states: IDLE, WAIT_ACK, RELEASE.
- IDLE: if any req_i=1 and br_local_busy_i=0:
  - Select the first set req_i scanning rr_ptr, rr_ptr+1, … mod N_REQ.
  - On the same edge: br_data_o<=data_i[sel], grant_idx_o<=sel, br_req_o<=1, grant_valid_o<=1, go to WAIT_ACK.
  - Latency: req_i sampled high at edge k gives br_req_o=1 after edge k.
  - If br_local_busy_i=1, stay in IDLE with outputs unchanged.
- WAIT_ACK: br_req_o and br_data_o are held. On br_ack_i=1:
  - br_req_o<=0, ack_o[grant_idx_o]<=1 for exactly one cycle.
  - rr_ptr<=(grant_idx_o+1) mod N_REQ, wrapping at N_REQ-1 to 0.
  - Go to RELEASE.
  - br_local_busy_i is ignored in this state.
- RELEASE: one cycle while the grantee drops req_i. ack_o<=0, grant_valid_o<=0, go to IDLE. The same requester cannot be re-granted earlier than two cycles after its ack_o pulse.
- br_ack_i outside WAIT_ACK is ignored. It must not pulse ack_o or change state.
- A requester dropping req_i during WAIT_ACK is a protocol violation. The transfer still completes and ack_o is still pulsed.
- br_data_o keeps the last granted value after completion. Only a new grant changes it.
- stall_cnt_o increments by 1 in each cycle with state=WAIT_ACK and br_ack_i=0. It saturates at all-ones. stall_clr_i has priority over increment and sets the counter to 0.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,N_REQ-1,0.
- A new grant takes at least three cycles: grant, ack, release.

Decomposition:
- DMNIPkg: reuse brlite_out_t. Add a brlite_arb_state_t enum (IDLE, WAIT_ACK, RELEASE) and the BRLITE_ARB_NREQ default constant.
- Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs sel index and any flag. It is testable standalone.

Test Plan:
1. Single requester: req_i=3'b001 with data payload=32'hCAFE0001, router acks 2 cycles after br_req_o.
   -> br_req_o high 1 cycle after req_i, br_data_o.payload=CAFE0001, ack_o=001 for one cycle, stall_cnt_o=2.
2. All requesting continuously, router acks immediately.
   -> grant_idx_o sequence 0,1,2,0,1,2, with each grant three cycles apart.
3. br_local_busy_i=1 for 5 cycles while req_i=010.
   -> br_req_o stays 0 for those cycles, then asserts the cycle after busy falls, with grant_idx_o=1.
4. rr_ptr=2 (after granting 1), req_i=3'b011.
   -> rr_ptr=2 wraps the scan, so requester 0 is granted before 1.
5. Assert rst_ni=0 in WAIT_ACK.
   -> all outputs return to reset values asynchronously, no ack_o pulse, and the next grant starts from index 0.
6. br_ack_i pulse in IDLE; stall_cnt_o held at all-ones with STALL_CNT_W=4.
   -> no state change and no ack_o. The counter stays 4'hF until stall_clr_i, then reads 0.
